// File: rtl/onehot_seq_checker.sv
// Checks a 16-bit one-hot decode bus on the receive side. It encodes the bus back
// to an index, verifies a +1 mod 16 progression and reports lock status and error events.
module onehot_seq_checker #(
    parameter int LOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic [15:0] decode_in,
    output logic [3:0]  code,
    output logic        code_valid,
    output logic        onehot_err,
    output logic        seq_err,
    output logic        locked,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_VAL = 4'(LOCK_COUNT);

    state_t      state_reg;
    logic [3:0]  expected_reg;
    logic [3:0]  run_reg;
    logic [3:0]  code_reg;
    logic        code_valid_reg;
    logic        onehot_err_reg;
    logic        seq_err_reg;
    logic [7:0]  err_count_reg;

    logic        valid_oh;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [3:0]  run_next;
    logic        mismatch;
    logic        err_event;
    logic [15:0] idx_terms [4];

    // Each index bit is the OR of the bus lines whose position has that bit set.
    // The result is only meaningful when the bus is one-hot.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_enc_bit
            for (genvar gj = 0; gj < 16; gj++) begin : g_enc_line
                assign idx_terms[gi][gj] = decode_in[gj] & (((gj >> gi) & 1) == 1);
            end
            assign idx[gi] = |idx_terms[gi];
        end
    endgenerate

    always_comb begin
        valid_oh  = (decode_in != 16'd0) && ((decode_in & (decode_in - 16'd1)) == 16'd0);
        idx_next  = idx + 4'd1;
        run_next  = run_reg + 4'd1;
        mismatch  = valid_oh && (state_reg != IDLE) && (idx != expected_reg);
        err_event = sample_en && (!valid_oh || mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            expected_reg   <= 4'd0;
            run_reg        <= 4'd0;
            code_reg       <= 4'd0;
            code_valid_reg <= 1'b0;
            onehot_err_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            err_count_reg  <= 8'd0;
        end else begin
            code_valid_reg <= 1'b0;
            onehot_err_reg <= 1'b0;
            seq_err_reg    <= 1'b0;
            if (err_event && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
            if (sample_en) begin
                if (!valid_oh) begin
                    onehot_err_reg <= 1'b1;
                    state_reg      <= IDLE;
                    run_reg        <= 4'd0;
                end else begin
                    code_reg       <= idx;
                    code_valid_reg <= 1'b1;
                    expected_reg   <= idx_next;
                    case (state_reg)
                        IDLE: begin
                            state_reg <= ACQUIRE;
                            run_reg   <= 4'd1;
                        end
                        ACQUIRE: begin
                            if (mismatch) begin
                                seq_err_reg <= 1'b1;
                                run_reg     <= 4'd1;
                            end else begin
                                run_reg <= run_next;
                                if (run_next == LOCK_VAL) begin
                                    state_reg <= LOCKED;
                                end
                            end
                        end
                        LOCKED: begin
                            if (mismatch) begin
                                seq_err_reg <= 1'b1;
                                state_reg   <= ACQUIRE;
                                run_reg     <= 4'd1;
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            run_reg   <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign code       = code_reg;
    assign code_valid = code_valid_reg;
    assign onehot_err = onehot_err_reg;
    assign seq_err    = seq_err_reg;
    assign locked     = (state_reg == LOCKED);
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_onehot_seq_checker.sv
// Randomised and directed bench for onehot_seq_checker, checked every cycle against
// a streak-counting reference model of the sequence rules.
module tb_onehot_seq_checker;

    localparam int LOCK_COUNT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic [15:0] decode_in;
    logic [3:0]  code;
    logic        code_valid;
    logic        onehot_err;
    logic        seq_err;
    logic        locked;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // reference model state
    int m_code, m_cv, m_oe, m_se, m_locked, m_cnt;
    int have_prev, prev_idx, streak;

    onehot_seq_checker #(.LOCK_COUNT(LOCK_COUNT)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .decode_in  (decode_in),
        .code       (code),
        .code_valid (code_valid),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a valid sample continues the streak if it is previous+1 mod 16,
    // lock holds whenever the streak has reached LOCK_COUNT.
    always @(posedge clk) begin
        if (rst) begin
            m_code = 0; m_cv = 0; m_oe = 0; m_se = 0; m_locked = 0; m_cnt = 0;
            have_prev = 0; prev_idx = 0; streak = 0;
        end else begin
            m_cv = 0; m_oe = 0; m_se = 0;
            if (sample_en) begin
                if ($countones(decode_in) != 1) begin
                    m_oe = 1;
                    have_prev = 0;
                    streak = 0;
                    if (m_cnt < 255) m_cnt++;
                end else begin
                    int idx;
                    idx = 0;
                    for (int i = 0; i < 16; i++) if (decode_in[i]) idx = i;
                    m_cv = 1;
                    m_code = idx;
                    if (!have_prev) begin
                        streak = 1;
                    end else if (idx != (prev_idx + 1) % 16) begin
                        m_se = 1;
                        streak = 1;
                        if (m_cnt < 255) m_cnt++;
                    end else begin
                        streak++;
                    end
                    have_prev = 1;
                    prev_idx = idx;
                end
                m_locked = (streak >= LOCK_COUNT) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("code",       int'(code),       m_code);
            chk("code_valid", int'(code_valid), m_cv);
            chk("onehot_err", int'(onehot_err), m_oe);
            chk("seq_err",    int'(seq_err),    m_se);
            chk("locked",     int'(locked),     m_locked);
            chk("err_count",  int'(err_count),  m_cnt);
        end
    end

    task automatic step(input logic en, input logic [15:0] d);
        sample_en = en;
        decode_in = d;
        @(posedge clk);
        #1;
        $display("txn en=%0b in=%04h -> code=%0d cv=%0b oe=%0b se=%0b lk=%0b cnt=%0d",
                 en, d, code, code_valid, onehot_err, seq_err, locked, err_count);
    endtask

    function automatic logic [15:0] oh(input int i);
        logic [15:0] v;
        v = 16'd1;
        return v << (i % 16);
    endfunction

    initial begin
        int cur;
        rst = 1'b1;
        sample_en = 1'b0;
        decode_in = 16'd0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        step(1'b1, 16'h0001);   // rst overrides sample_en
        chk("reset_code",   int'(code), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_cv",     int'(code_valid), 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) step(1'b1, oh(i));
        chk("lit_code3", int'(code), 3);
        chk("lit_lock4", int'(locked), 1);
        chk("lit_model_lock4", m_locked, 1);
        chk("lit_cnt0", int'(err_count), 0);

        for (int i = 4; i < 17; i++) step(1'b1, oh(i));
        chk("lit_wrap_code", int'(code), 0);
        chk("lit_wrap_lock", int'(locked), 1);

        for (int i = 1; i < 6; i++) step(1'b1, oh(i));
        step(1'b1, 16'h0100);
        chk("lit_jump_se",   int'(seq_err), 1);
        chk("lit_jump_lock", int'(locked), 0);
        chk("lit_jump_cnt",  int'(err_count), 1);
        for (int i = 9; i < 12; i++) step(1'b1, oh(i));
        chk("lit_relock", int'(locked), 1);

        step(1'b1, 16'h0000);
        chk("lit_zero_oe", int'(onehot_err), 1);
        step(1'b1, 16'h0003);
        chk("lit_multi_oe", int'(onehot_err), 1);
        chk("lit_hold_code", int'(code), 11);
        chk("lit_cnt3", int'(err_count), 3);
        chk("lit_model_cnt3", m_cnt, 3);

        step(1'b1, oh(7));
        step(1'b1, oh(7));      // held value counts as a mismatch
        chk("lit_held_se", int'(seq_err), 1);

        for (int i = 0; i < 10; i++) step(1'b0, 16'($urandom));
        chk("lit_idle_code", int'(code), 7);

        cur = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 2) step(1'b0, 16'($urandom));
            else if (r < 4) step(1'b1, 16'($urandom));
            else if (r < 6) begin
                cur = $urandom_range(0, 15);
                step(1'b1, oh(cur));
            end else begin
                cur = (cur + 1) % 16;
                step(1'b1, oh(cur));
            end
        end

        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? oh(0) : oh(5));
        chk("lit_sat", int'(err_count), 255);

        rst = 1'b1;
        step(1'b1, oh(6));
        rst = 1'b0;
        chk("lit_rst_cnt",  int'(err_count), 0);
        chk("lit_rst_code", int'(code), 0);
        chk("lit_rst_lock", int'(locked), 0);
        step(1'b1, oh(9));      // first sample after reset starts fresh
        chk("lit_post_se", int'(seq_err), 0);
        chk("lit_post_code", int'(code), 9);
        for (int i = 10; i < 14; i++) step(1'b1, oh(i));

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onehot_seq_checker.md
# onehot_seq_checker

Receive-side companion to the one-hot decoder counter. Samples a 16-bit one-hot decode bus and encodes it back to a 4-bit code. Checks that successive samples step by +1 modulo 16, and reports lock status, one-hot violations, sequence breaks and a saturating error count. Sits downstream of the decoder counter as a self-check and monitor block.

## Interface
Parameters:
- LOCK_COUNT, 4: number of consecutive in-sequence valid samples needed to declare lock; legal range 2..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  qualifies decode_in on this edge; when low the block holds all state.
- decode_in  input  16  one-hot decode bus from the decoder counter.
- code  output  4  index of the last valid one-hot sample; registered.
- code_valid  output  1  one-cycle pulse: code was updated by this sample.
- onehot_err  output  1  one-cycle pulse: sampled bus had zero bits set or more than one bit set.
- seq_err  output  1  one-cycle pulse: valid sample's index differed from the expected index.
- locked  output  1  high while the FSM is in LOCKED.
- err_count  output  8  count of onehot_err plus seq_err events; saturates at 255.

## Operation
- Combinational front end:
  - valid_oh = exactly one bit of decode_in set.
  - idx = position of that bit, 0..15.
- Internal registers:
  - state: IDLE, ACQUIRE or LOCKED.
  - expected: 4 bits.
  - run: 4 bits; counts consecutive in-sequence samples, including the first.
- sample_en low: no state change; code_valid, onehot_err and seq_err are 0.
- sample_en high and valid_oh = 0:
  - onehot_err = 1.
  - code holds its value; code_valid = 0.
  - state goes to IDLE and run clears. Applies from any state.
- sample_en high and valid_oh = 1:
  - code <= idx and code_valid = 1.
  - IDLE: go to ACQUIRE, run <= 1, expected <= idx+1. No seq_err.
  - ACQUIRE, idx == expected: run <= run+1, expected <= idx+1. If run+1 == LOCK_COUNT, go to LOCKED.
  - ACQUIRE, idx != expected: seq_err = 1, run <= 1, expected <= idx+1, stay in ACQUIRE.
  - LOCKED, idx == expected: stay in LOCKED, expected <= idx+1. run is don't-care.
  - LOCKED, idx != expected: seq_err = 1, go to ACQUIRE, run <= 1, expected <= idx+1.
- Arithmetic:
  - expected wraps 15 -> 0 (4-bit modulo add).
  - err_count <= err_count + 1 on onehot_err or seq_err, holding at 255.
  - onehot_err and seq_err are mutually exclusive by construction, so the increment is at most 1 per cycle.

## Timing
- Outputs are registered. Latency is 1 cycle from a sampled edge to the output change.
- Pulses last exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- locked rises on the edge that samples the LOCK_COUNT-th consecutive in-sequence value. It falls on the edge that samples a mismatch or an invalid bus.
- Reset values, taking effect on the first rising edge with rst = 1:
  - code = 0, code_valid = 0, onehot_err = 0, seq_err = 0, locked = 0, err_count = 0.
  - state = IDLE, run = 0, expected = 0.
- rst overrides sample_en.
- Reset mid-operation discards lock and the error count immediately. The first sample after rst falls is treated as an IDLE sample.
- A held value with sample_en high (e.g. decoder enable low while the checker keeps sampling) is a mismatch: seq_err fires. Integrators must gate sample_en with the counter's enable.

## Test plan
- Reset, then feed 16'h0001, 16'h0002, 16'h0004, 16'h0008 with sample_en = 1 -> code = 0,1,2,3 and code_valid high each cycle. locked rises after the 4th edge. seq_err = 0 and err_count = 0.
- While locked, walk 16'h4000, 16'h8000, 16'h0001 (code 14,15,0) -> wrap is accepted, locked stays 1, no errors.
- While locked at code 5, feed 16'h0100 (idx 8) -> seq_err pulses, locked falls, err_count = 1. Then 16'h0200, 16'h0400, 16'h0800 -> locked rises again on the 4th sample counted from idx 8.
- Feed 16'h0000, then 16'h0003 -> onehot_err pulses twice, code holds its last value, state IDLE, err_count increments by 2.
- Hold sample_en = 0 for 10 cycles with random decode_in -> no pulses and no change to any output.
- Force 300 alternating mismatches -> err_count saturates at 255. Then assert rst for one cycle -> all outputs return to 0.
